// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states, opcodes,
// ALU operations and the per-state control word.
package multicycle_controller_pkg;

    localparam logic [3:0] StFetch    = 4'd0;
    localparam logic [3:0] StDecode   = 4'd1;
    localparam logic [3:0] StMemAdr   = 4'd2;
    localparam logic [3:0] StMemRead  = 4'd3;
    localparam logic [3:0] StMemWb    = 4'd4;
    localparam logic [3:0] StMemWrite = 4'd5;
    localparam logic [3:0] StExecuteR = 4'd6;
    localparam logic [3:0] StExecuteI = 4'd7;
    localparam logic [3:0] StAluWb    = 4'd8;
    localparam logic [3:0] StJal      = 4'd9;
    localparam logic [3:0] StBeq      = 4'd10;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpBranch = 7'b1100011;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b101;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    typedef struct packed {
        logic       pcupdate;
        logic       branch;
        logic       adrsrc;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic [1:0] resultsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
    } ctrl_t;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps ALUOp and instruction function fields to an ALU operation.
module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = AluAdd;
        case (aluop)
            AluOpAdd: alucontrol = AluAdd;
            AluOpSub: alucontrol = AluSub;
            AluOpFunct: begin
                case (funct3)
                    // Only R-type (op[5]=1) can encode sub; addi with imm[10] set stays add.
                    3'b000:  alucontrol = (op5 && funct7b5) ? AluSub : AluAdd;
                    3'b010:  alucontrol = AluSlt;
                    3'b110:  alucontrol = AluOr;
                    3'b111:  alucontrol = AluAnd;
                    default: alucontrol = AluAdd;
                endcase
            end
            default: alucontrol = AluAdd;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-FSM control unit for a multicycle RISC-V datapath (lw, sw, R/I ALU, jal, beq).
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic [3:0] State
);

    logic [3:0] state_q, state_d;
    ctrl_t      ctrl;

    always_ff @(posedge clk) begin
        if (reset) state_q <= StFetch;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                case (op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecuteR;
                    OpIType:         state_d = StExecuteI;
                    OpJal:           state_d = StJal;
                    OpBranch:        state_d = StBeq;
                    default:         state_d = StFetch;
                endcase
            end
            StMemAdr:   state_d = (op == OpLoad) ? StMemRead : StMemWrite;
            StMemRead:  state_d = StMemWb;
            StExecuteR: state_d = StAluWb;
            StExecuteI: state_d = StAluWb;
            StJal:      state_d = StAluWb;
            default:    state_d = StFetch;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            StFetch: begin
                ctrl.irwrite   = 1'b1;
                ctrl.alusrcb   = 2'b10;
                ctrl.resultsrc = 2'b10;
                ctrl.pcupdate  = 1'b1;
            end
            StDecode: begin
                ctrl.alusrca = 2'b01;
                ctrl.alusrcb = 2'b01;
            end
            StMemAdr: begin
                ctrl.alusrca = 2'b10;
                ctrl.alusrcb = 2'b01;
            end
            StMemRead: ctrl.adrsrc = 1'b1;
            StMemWb: begin
                ctrl.resultsrc = 2'b01;
                ctrl.regwrite  = 1'b1;
            end
            StMemWrite: begin
                ctrl.adrsrc   = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            StExecuteR: begin
                ctrl.alusrca = 2'b10;
                ctrl.aluop   = AluOpFunct;
            end
            StExecuteI: begin
                ctrl.alusrca = 2'b10;
                ctrl.alusrcb = 2'b01;
                ctrl.aluop   = AluOpFunct;
            end
            StAluWb: ctrl.regwrite = 1'b1;
            StJal: begin
                ctrl.alusrca  = 2'b01;
                ctrl.alusrcb  = 2'b10;
                ctrl.pcupdate = 1'b1;
            end
            StBeq: begin
                ctrl.alusrca = 2'b10;
                ctrl.aluop   = AluOpSub;
                ctrl.branch  = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    // Architectural write enables are held off while reset is asserted.
    assign PCWrite   = (ctrl.pcupdate | (ctrl.branch & Zero)) & ~reset;
    assign IRWrite   = ctrl.irwrite & ~reset;
    assign RegWrite  = ctrl.regwrite & ~reset;
    assign MemWrite  = ctrl.memwrite & ~reset;
    assign AdrSrc    = ctrl.adrsrc;
    assign ResultSrc = ctrl.resultsrc;
    assign ALUSrcA   = ctrl.alusrca;
    assign ALUSrcB   = ctrl.alusrcb;
    assign State     = state_q;

    always_comb begin
        case (op)
            OpStore:  ImmSrc = 2'b01;
            OpBranch: ImmSrc = 2'b10;
            OpJal:    ImmSrc = 2'b11;
            default:  ImmSrc = 2'b00;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop      (ctrl.aluop),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7b5   (funct7b5),
        .alucontrol (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: instruction-path model compared every cycle plus directed literal checks.
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
        .State      (State)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    int rw_cnt   = 0;
    int mw_cnt   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the whole state path of an instruction is looked up from its opcode.
    logic [3:0] m_state;
    logic [3:0] m_path[$];
    bit         m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset === 1'b1) begin
            m_state = StFetch;
            m_path.delete();
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_path.size() == 0) begin
                case (op)
                    OpLoad:   m_path = '{StDecode, StMemAdr, StMemRead, StMemWb, StFetch};
                    OpStore:  m_path = '{StDecode, StMemAdr, StMemWrite, StFetch};
                    OpRType:  m_path = '{StDecode, StExecuteR, StAluWb, StFetch};
                    OpIType:  m_path = '{StDecode, StExecuteI, StAluWb, StFetch};
                    OpJal:    m_path = '{StDecode, StJal, StAluWb, StFetch};
                    OpBranch: m_path = '{StDecode, StBeq, StFetch};
                    default:  m_path = '{StDecode, StFetch};
                endcase
            end
            m_state = m_path.pop_front();
        end
    end

    function automatic logic [2:0] alu_funct(input logic [2:0] f3, input logic o5, input logic f7);
        if (f3 == 3'b000) return (o5 && f7) ? 3'b001 : 3'b000;
        if (f3 == 3'b010) return 3'b101;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b111) return 3'b010;
        return 3'b000;
    endfunction

    always @(negedge clk) begin
        if (RegWrite === 1'b1) rw_cnt++;
        if (MemWrite === 1'b1) mw_cnt++;
    end

    always @(negedge clk) begin
        logic       e_pcu, e_br, e_adr, e_mw, e_irw, e_rw;
        logic [1:0] e_res, e_sa, e_sb, e_imm;
        logic [2:0] e_alu;
        if (m_valid) begin
            e_pcu = 0; e_br = 0; e_adr = 0; e_mw = 0; e_irw = 0; e_rw = 0;
            e_res = 0; e_sa = 0; e_sb = 0; e_alu = 3'b000;
            case (m_state)
                StFetch:    begin e_irw = 1; e_sb = 2; e_res = 2; e_pcu = 1; end
                StDecode:   begin e_sa = 1; e_sb = 1; end
                StMemAdr:   begin e_sa = 2; e_sb = 1; end
                StMemRead:  e_adr = 1;
                StMemWb:    begin e_res = 1; e_rw = 1; end
                StMemWrite: begin e_adr = 1; e_mw = 1; end
                StExecuteR: begin e_sa = 2; e_alu = alu_funct(funct3, op[5], funct7b5); end
                StExecuteI: begin e_sa = 2; e_sb = 1; e_alu = alu_funct(funct3, op[5], funct7b5); end
                StAluWb:    e_rw = 1;
                StJal:      begin e_sa = 1; e_sb = 2; e_pcu = 1; end
                StBeq:      begin e_sa = 2; e_alu = 3'b001; e_br = 1; end
                default:    ;
            endcase
            e_imm = (op == OpStore) ? 2'b01 : (op == OpBranch) ? 2'b10 :
                    (op == OpJal) ? 2'b11 : 2'b00;
            chk("State", State, m_state);
            chk("PCWrite", PCWrite, !reset && (e_pcu || (e_br && Zero)));
            chk("AdrSrc", AdrSrc, e_adr);
            chk("MemWrite", MemWrite, e_mw && !reset);
            chk("IRWrite", IRWrite, e_irw && !reset);
            chk("RegWrite", RegWrite, e_rw && !reset);
            chk("ResultSrc", ResultSrc, e_res);
            chk("ALUSrcA", ALUSrcA, e_sa);
            chk("ALUSrcB", ALUSrcB, e_sb);
            chk("ALUControl", ALUControl, e_alu);
            chk("ImmSrc", ImmSrc, e_imm);
        end
    end

    // Per-cycle record of one instruction; index 0 is its FETCH cycle.
    logic [3:0] rec_state[16];
    logic       rec_pcw[16];
    logic       rec_rw[16];
    logic [1:0] rec_res[16];
    logic [2:0] rec_alu[16];
    int         rw0, mw0;

    task automatic record(input int k);
        rec_state[k] = State;
        rec_pcw[k]   = PCWrite;
        rec_rw[k]    = RegWrite;
        rec_res[k]   = ResultSrc;
        rec_alu[k]   = ALUControl;
    endtask

    // Called a little after a rising edge that starts a FETCH cycle; returns in the next FETCH.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int lat, input string nm);
        int n;
        op = o; funct3 = f3; funct7b5 = f7; Zero = z;
        rw0 = rw_cnt; mw0 = mw_cnt;
        #1;
        record(0);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (State != StFetch && n < 16) record(n);
        end while (State != StFetch && n < 12);
        chk({nm, " latency"}, n, lat);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset State", State, 0);
        chk("reset IRWrite", IRWrite, 0);
        chk("reset PCWrite", PCWrite, 0);
        reset = 1'b0;
        #1;
        chk("first fetch IRWrite", IRWrite, 1);
        chk("first fetch PCWrite", PCWrite, 1);
        @(posedge clk); #1;
        chk("after fetch State", State, 1);
        chk("decode IRWrite", IRWrite, 0);
        chk("decode PCWrite", PCWrite, 0);
        // Opcode 0 is illegal, so this instruction comes back to FETCH now.
        @(posedge clk); #1;
        chk("illegal0 back to fetch", State, 0);

        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 5, "lw");
        chk("lw memadr", rec_state[2], 2);
        chk("lw memread", rec_state[3], 3);
        chk("lw memwb", rec_state[4], 4);
        chk("lw regwrite in memwb", rec_rw[4], 1);
        chk("lw resultsrc in memwb", rec_res[4], 1);
        chk("lw regwrite pulses", rw_cnt - rw0, 1);

        run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 4, "sub");
        chk("sub alucontrol", rec_alu[2], 1);
        chk("sub regwrite aluwb", rec_rw[3], 1);
        run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 4, "add");
        chk("add alucontrol", rec_alu[2], 0);
        run_instr(7'b0110011, 3'b010, 1'b0, 1'b0, 4, "slt");
        chk("slt alucontrol", rec_alu[2], 5);
        run_instr(7'b0110011, 3'b110, 1'b0, 1'b0, 4, "or");
        chk("or alucontrol", rec_alu[2], 3);
        run_instr(7'b0110011, 3'b111, 1'b0, 1'b0, 4, "and");
        chk("and alucontrol", rec_alu[2], 2);
        run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 4, "addi");
        chk("addi alucontrol", rec_alu[2], 0);
        run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 4, "jal");
        chk("jal pcwrite", rec_pcw[2], 1);
        run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 4, "sw");
        chk("sw memwrite pulses", mw_cnt - mw0, 1);

        run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 3, "beq taken");
        chk("beq taken pcwrite", rec_pcw[2], 1);
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 3, "beq not taken");
        chk("beq not taken pcwrite", rec_pcw[2], 0);

        run_instr(7'b1111111, 3'b000, 1'b0, 1'b1, 2, "illegal");
        chk("illegal fetch pcwrite", rec_pcw[0], 1);
        chk("illegal decode pcwrite", rec_pcw[1], 0);
        chk("illegal regwrite pulses", rw_cnt - rw0, 0);
        chk("illegal memwrite pulses", mw_cnt - mw0, 0);

        // sw interrupted by reset while in MEMADR.
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
        mw0 = mw_cnt;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("sw reached memadr", State, 2);
        reset = 1'b1;
        #1;
        chk("memadr under reset alusrca", ALUSrcA, 2);
        chk("memadr under reset memwrite", MemWrite, 0);
        @(posedge clk); #1;
        chk("reset mid-instr State", State, 0);
        chk("reset fetch irwrite", IRWrite, 0);
        reset = 1'b0;
        run_instr(7'b0010011, 3'b111, 1'b0, 1'b0, 4, "andi after reset");
        chk("andi alucontrol", rec_alu[2], 2);
        chk("aborted sw memwrite pulses", mw_cnt - mw0, 0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
